// File: rtl/stage_if.sv
// rtl/stage_if.sv - RV32 instruction-fetch stage: PC, in-order fetch, prefetch buffer, IF/ID register
//
// Optional build macro: IF_BYPASS_EN
//   defined   - a kept response that finds the buffer empty (and no stall) is written
//               straight into IF/ID in the same cycle
//   undefined - every kept response goes through the prefetch buffer
//
// Parameters:
//   RESET_PC   PC loaded at reset
//   BUF_DEPTH  prefetch buffer / tag FIFO entries (power of two, >= 2)
//
// Ports:
//   clk          pipeline clock, rising edge
//   rst          asynchronous active-low reset
//   imem_req     fetch request valid
//   imem_addr    fetch address (current PC)
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  read data valid (in-order responses)
//   imem_rdata   instruction word
//   ctrl_stall   decode hazard stall, hold IF/ID
//   br_taken     redirect + flush from execute
//   br_target    redirect PC (bits [1:0] forced to 0)
//   if_inst      IF/ID instruction
//   if_pc        IF/ID PC
//   if_valid     IF/ID holds a real fetched instruction
module stage_if #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        ctrl_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_valid
);

    localparam int          PW      = $clog2(BUF_DEPTH);
    localparam int          CW      = $clog2(BUF_DEPTH + 1);
    localparam int          CW1     = CW + 1;
    localparam logic [CW:0] DEPTH_W = CW1'(BUF_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   pc;
    logic          started;
    logic [CW-1:0] outs;
    logic [CW-1:0] disc;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] tag_rd;

    logic [31:0] buf_inst [BUF_DEPTH];
    logic [31:0] buf_pc   [BUF_DEPTH];
    logic [31:0] tag_pc   [BUF_DEPTH];

    logic [CW:0] occ;
    logic        grant;
    logic        resp_keep;
    logic        bypass;
    logic        push;
    logic        pop;
    logic [31:0] resp_pc;
    logic        br_target_unused;

    assign br_target_unused = ^br_target[1:0];

    // Outstanding requests plus buffered words never exceed the buffer size,
    // so every response is guaranteed a slot. 'started' holds the request low
    // until the first edge after reset release.
    assign occ       = {1'b0, outs} + {1'b0, count};
    assign imem_req  = started && !br_taken && (occ < DEPTH_W);
    assign imem_addr = pc;
    assign grant     = imem_req && imem_gnt;

    // The tag FIFO pops on every response, kept or discarded, so it always
    // holds exactly the PCs of the outstanding requests.
    assign resp_pc   = tag_pc[tag_rd];
    assign resp_keep = imem_rvalid && (disc == '0) && !br_taken;

`ifdef IF_BYPASS_EN
    assign bypass = resp_keep && (count == '0) && !ctrl_stall;
`else
    assign bypass = 1'b0;
`endif

    assign push = resp_keep && !bypass;
    assign pop  = !br_taken && !ctrl_stall && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= resp_pc;
        end
        if (grant) begin
            tag_pc[tag_wr] <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            started  <= 1'b0;
            outs     <= '0;
            disc     <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            if_inst  <= NOP;
            if_pc    <= RESET_PC;
            if_valid <= 1'b0;
        end else begin
            started <= 1'b1;
            outs    <= outs + CW'(grant) - CW'(imem_rvalid);

            if (grant) begin
                tag_wr <= tag_wr + PW'(1);
            end
            if (imem_rvalid) begin
                tag_rd <= tag_rd + PW'(1);
            end

            if (br_taken) begin
                // Everything still in flight belongs to the old path; a response
                // arriving this very cycle is dropped here, not counted.
                pc     <= {br_target[31:2], 2'b00};
                disc   <= outs - CW'(imem_rvalid);
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (grant) begin
                    pc <= pc + 32'd4;
                end
                if (imem_rvalid && (disc != '0)) begin
                    disc <= disc - CW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end

            if (br_taken) begin
                if_inst  <= NOP;
                if_valid <= 1'b0;
            end else if (ctrl_stall) begin
                if_inst  <= if_inst;
                if_pc    <= if_pc;
                if_valid <= if_valid;
            end else if (pop) begin
                if_inst  <= buf_inst[rd_ptr];
                if_pc    <= buf_pc[rd_ptr];
                if_valid <= 1'b1;
            end else if (bypass) begin
                if_inst  <= imem_rdata;
                if_pc    <= resp_pc;
                if_valid <= 1'b1;
            end else begin
                if_inst  <= NOP;
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// tb/tb_stage_if.sv - self-checking bench for stage_if with a randomized in-order memory model
module tb_stage_if;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_BYPASS_EN
    localparam int FIRST_TICK  = 3;
    localparam int WIN_VALIDS  = 12;
`else
    localparam int FIRST_TICK  = 4;
    localparam int WIN_VALIDS  = 8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        ctrl_stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;

    always #5 clk = ~clk;

    stage_if #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ctrl_stall  (ctrl_stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_valid    (if_valid)
    );

    int n_vec = 0;
    int n_err = 0;

    // memory model: granted addresses with the edge before which they may respond
    logic [31:0] mq_addr  [$];
    int          mq_ready [$];
    int          edge_n   = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          gnt_pct  = 100;

    // reference model: next fetch address and next instruction expected in IF/ID
    logic [31:0] exp_pc   = 32'h0;
    logic [31:0] exp_next = 32'h0;
    int          valid_cnt = 0;
    logic        last_req;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    // One pipeline cycle: memory answers, request is granted, then IF/ID is
    // checked against program order (restart at target on a redirect).
    task automatic run_cycle();
        logic        g;
        logic        br_now;
        logic        st_now;
        logic [31:0] tgt;
        logic [31:0] p_inst;
        logic [31:0] p_pc;
        logic        p_valid;
        if (mq_addr.size() > 0 && mq_ready[0] <= edge_n + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        last_req  = imem_req;
        last_addr = imem_addr;
        g = imem_req && ($urandom_range(99, 0) < gnt_pct);
        imem_gnt = g;
        if (imem_req === 1'b1) begin
            n_vec++;
            if (imem_addr !== exp_pc) begin
                n_err++;
                $display("FAIL fetch_addr: got %h expected %h", imem_addr, exp_pc);
            end
        end
        br_now  = br_taken;
        st_now  = ctrl_stall;
        tgt     = {br_target[31:2], 2'b00};
        p_inst  = if_inst;
        p_pc    = if_pc;
        p_valid = if_valid;
        @(posedge clk);
        edge_n++;
        if (imem_rvalid) begin
            void'(mq_addr.pop_front());
            void'(mq_ready.pop_front());
        end
        if (g) begin
            mq_addr.push_back(last_addr);
            mq_ready.push_back(edge_n + int'($urandom_range(lat_max, lat_min)));
        end
        if (br_now) begin
            exp_pc   = tgt;
            exp_next = tgt;
        end else if (g) begin
            exp_pc = exp_pc + 32'd4;
        end
        #1;
        n_vec++;
        if (br_now) begin
            if (if_valid !== 1'b0 || if_inst !== NOP || if_pc !== p_pc) begin
                n_err++;
                $display("FAIL flush: got v=%b inst=%h pc=%h expected v=0 inst=%h pc=%h",
                         if_valid, if_inst, if_pc, NOP, p_pc);
            end
        end else if (st_now) begin
            if (if_valid !== p_valid || if_inst !== p_inst || if_pc !== p_pc) begin
                n_err++;
                $display("FAIL stall_hold: got v=%b inst=%h pc=%h expected v=%b inst=%h pc=%h",
                         if_valid, if_inst, if_pc, p_valid, p_inst, p_pc);
            end
        end else if (if_valid === 1'b1) begin
            if (if_pc !== exp_next || if_inst !== mem_word(exp_next)) begin
                n_err++;
                $display("FAIL order: got pc=%h inst=%h expected pc=%h inst=%h",
                         if_pc, if_inst, exp_next, mem_word(exp_next));
            end
            exp_next = exp_next + 32'd4;
            valid_cnt++;
        end else begin
            if (if_valid !== 1'b0 || if_inst !== NOP) begin
                n_err++;
                $display("FAIL bubble: got v=%b inst=%h expected v=0 inst=%h",
                         if_valid, if_inst, NOP);
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_pc(input logic [31:0] pc, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            run_cycle();
            if (if_valid === 1'b1 && if_pc === pc) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        br_taken    = 1'b0;
        ctrl_stall  = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        mq_addr.delete();
        mq_ready.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (if_inst !== NOP || if_valid !== 1'b0 || if_pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_ifid: got inst=%h v=%b pc=%h expected %h 0 0", if_inst, if_valid, if_pc, NOP);
        end
        n_vec++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_req: got req=%b addr=%h expected 0 0", imem_req, imem_addr);
        end
        exp_pc   = 32'h0;
        exp_next = 32'h0;
        rst      = 1'b1;
        run_cycle();
        n_vec++;
        if (last_req !== 1'b0) begin
            n_err++;
            $display("FAIL release_req: got %b expected 0", last_req);
        end
        run_cycle();
        n_vec++;
        if (last_req !== 1'b1 || last_addr !== 32'h0) begin
            n_err++;
            $display("FAIL first_req: got req=%b addr=%h expected 1 0", last_req, last_addr);
        end
    endtask

    task automatic test_straight();
        int first;
        int base;
        first = 0;
        for (int t = 3; t <= 10 && first == 0; t++) begin
            run_cycle();
            if (if_valid === 1'b1) first = t;
        end
        n_vec++;
        if (first != FIRST_TICK) begin
            n_err++;
            $display("FAIL first_latency: got %0d expected %0d", first, FIRST_TICK);
        end
        base = valid_cnt;
        repeat (12) run_cycle();
        n_vec++;
        if (valid_cnt - base != WIN_VALIDS) begin
            n_err++;
            $display("FAIL throughput: got %0d expected %0d", valid_cnt - base, WIN_VALIDS);
        end
    endtask

    task automatic test_stall();
        bit found;
        wait_pc(32'h8, 10, found);
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL stall_reach: got none expected pc 00000008");
        end
        ctrl_stall = 1'b1;
        repeat (3) run_cycle();
        ctrl_stall = 1'b0;
        n_vec++;
        if (last_req !== 1'b0 || if_pc !== 32'h8) begin
            n_err++;
            $display("FAIL stall_full: got req=%b pc=%h expected 0 00000008", last_req, if_pc);
        end
        wait_pc(32'h10, 8, found);
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL stall_resume: got none expected pc 00000010");
        end
    endtask

    task automatic test_branch();
        bit found;
        lat_min = 3;
        lat_max = 3;
        repeat (6) run_cycle();
        br_taken  = 1'b1;
        br_target = 32'h0000_0103;
        run_cycle();
        br_taken  = 1'b0;
        wait_pc(32'h100, 20, found);
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL branch_target: got none expected pc 00000100");
        end
        lat_min = 1;
        lat_max = 1;
        repeat (8) run_cycle();
    endtask

    task automatic test_flush_stall();
        br_taken   = 1'b1;
        ctrl_stall = 1'b1;
        br_target  = 32'h0000_0200;
        run_cycle();
        br_taken   = 1'b0;
        ctrl_stall = 1'b0;
        run_cycle();
        n_vec++;
        if (last_req !== 1'b1 || last_addr !== 32'h200) begin
            n_err++;
            $display("FAIL flush_refetch: got req=%b addr=%h expected 1 00000200", last_req, last_addr);
        end
        repeat (4) run_cycle();
    endtask

    task automatic test_wrap();
        bit found;
        br_taken  = 1'b1;
        br_target = 32'hFFFF_FFF9;
        run_cycle();
        br_taken  = 1'b0;
        wait_pc(32'h0, 12, found);
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL wrap: got none expected pc 00000000");
        end
    endtask

    task automatic test_random();
        int base;
        lat_min = 1;
        lat_max = 4;
        gnt_pct = 70;
        for (int i = 0; i < 1500; i++) begin
            ctrl_stall = ($urandom_range(99, 0) < 20);
            br_taken   = ($urandom_range(99, 0) < 4);
            br_target  = $urandom;
            run_cycle();
        end
        ctrl_stall = 1'b0;
        br_taken   = 1'b0;
        gnt_pct    = 100;
        base       = valid_cnt;
        repeat (20) run_cycle();
        n_vec++;
        if (valid_cnt - base < 5) begin
            n_err++;
            $display("FAIL random_progress: got %0d expected at least 5", valid_cnt - base);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_straight();
        test_reset();
        test_stall();
        test_branch();
        test_flush_stall();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stage_if.md
# stage_if

Instruction-fetch stage of the 5-stage RV32 pipeline. It owns the program counter and issues in-order fetch requests to instruction memory. Returned words go into a small prefetch buffer, and the block drives the IF/ID pipeline register that feeds `stage_id`. It also honours the decode-stage stall and applies branch redirects and flushes from execute.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded at reset.
- `BUF_DEPTH`, 2, prefetch buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address; equals current PC.
- `imem_gnt`  in  1  memory accepts the request this cycle; valid only while `imem_req`=1.
- `imem_rvalid`  in  1  read data valid; responses return in order, at least 1 cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `ctrl_stall`  in  1  hazard stall from decode; hold IF/ID.
- `br_taken`  in  1  redirect and flush request from execute.
- `br_target`  in  32  redirect PC; bits [1:0] ignored (forced 0).
- `if_inst`  out  32  IF/ID instruction, feeds `id_inst`.
- `if_pc`  out  32  IF/ID PC.
- `if_valid`  out  1  IF/ID holds a real fetched instruction.

## Operation
- State:
  - PC register.
  - Outstanding counter `outs`, 0..BUF_DEPTH.
  - Discard counter `disc`, 0..BUF_DEPTH.
  - Buffer FIFO (inst+pc) with read/write pointers and a count.
  - IF/ID register.
- Request rule:
  - `imem_req` = !`br_taken` && (`outs` + `count`) < BUF_DEPTH.
  - This guarantees every response has a buffer slot.
- Grant (`imem_req`&&`imem_gnt`):
  - `outs`++.
  - The address is pushed into an in-order PC tag FIFO (same depth).
  - PC <= PC+4, modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.
- Response (`imem_rvalid`):
  - `outs`--.
  - If `disc`>0: `disc`--, word dropped.
  - Otherwise the word and its tag PC are pushed into the buffer, or bypassed (see Configuration).
- IF/ID update, in priority order:
  1. `br_taken`: load NOP 32'h0000_0013, `if_valid`=0, `if_pc` unchanged.
  2. `ctrl_stall`: hold all three outputs.
  3. Buffer non-empty: pop the head into IF/ID, `if_valid`=1.
  4. Buffer empty: load NOP, `if_valid`=0.
- Redirect (`br_taken`):
  - PC <= {`br_target`[31:2],2'b00}.
  - Buffer emptied.
  - `disc` <= `outs` − (`imem_rvalid` ? 1 : 0).
  - The tag FIFO is drained alongside the discard.
- Simultaneous grant and response: `outs` unchanged.
- Simultaneous push and pop: `count` unchanged.
- `br_taken` overrides `ctrl_stall` and any response in the same cycle.

## Timing
Reset values (async on `rst`=0):
- PC=RESET_PC, `imem_addr`=RESET_PC, `imem_req`=0.
- `outs`=0, `disc`=0, buffer empty.
- `if_inst`=32'h0000_0013, `if_pc`=RESET_PC, `if_valid`=0.

Latencies:
- `imem_req` asserts in the first cycle after reset deassertion.
- Grant in cycle t with 1-cycle memory gives rvalid at t+1, and the instruction reaches IF/ID at the end of t+1 (bypass on).
- Sustained throughput with a 1-cycle memory: one instruction per cycle.
- Redirect penalty: IF/ID shows a NOP in the cycle after `br_taken`. The first target request issues the cycle after `br_taken`.

Reset mid-operation:
- All counters clear.
- Responses already in flight are not tracked. The memory is reset by the same `rst`, so no stale response can arrive.

## Configuration
- Macro `IF_BYPASS_EN`.
- Defined: a valid, non-discarded response that arrives when the buffer is empty and `ctrl_stall`=0 is written straight into IF/ID in the same cycle, bypassing the buffer. Load-to-IF/ID latency is 1 cycle from rvalid.
- Undefined: every response is written into the buffer and popped the following cycle. This adds 1 cycle of fetch latency and limits throughput to BUF_DEPTH / (mem latency+2). Functional ordering is identical in both builds.

## Test plan
- Reset: hold `rst`=0, then release → `if_inst`=0x00000013, `if_valid`=0, `if_pc`=RESET_PC; first `imem_req`=1 with `imem_addr`=0x0 one cycle after release.
- Straight-line code, always-grant 1-cycle memory, `IF_BYPASS_EN` on → `if_pc` sequence 0x0,0x4,0x8,0xC on consecutive cycles, `if_valid` continuously 1 after the first.
- `ctrl_stall`=1 for 3 cycles mid-stream → IF/ID holds pc 0x8; buffer fills to 2; `imem_req` drops to 0; after release 0xC and 0x10 follow with no loss or duplication.
- `br_taken`=1 with target 0x103 while 2 requests are outstanding → next IF/ID is NOP with `if_valid`=0; both stale responses are dropped; next valid `if_pc`=0x100.
- `br_taken` and `ctrl_stall` in the same cycle → flush wins; IF/ID becomes NOP; PC becomes the target.
- RESET_PC=0xFFFF_FFF8 → fetched PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
